cu_gen2: RTL and testbench

- Parametrised successor to the processor control unit.
- Multi-cycle Moore FSM: fetch, decode, execute and writeback for the 16-opcode ISA, including the matrix-walk strobes (mar/col/row).
- Generalised in bus width, opcode width and register-field width.
- Adds over the previous unit: real opcode dispatch, memory ready handshakes with timeout, conditional jump on the ALU zero flag, start/halt control, and a sticky error state.

---
 rtl/cu_gen2_if.sv | 55 +++++
 rtl/cu_gen2.sv | 190 +++++++++++++++++++
 tb/tb_cu_gen2.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cu_gen2_if.sv
// Bus bundle between cu_gen2 and its datapath/memories.
// instr_count exists only when CU_PERF_CNT_EN is defined.
interface cu_gen2_if #(
  parameter int BUS_WIDTH = 16,
  parameter int REG_SEL_W = 4,
  parameter int CNT_W     = 32
);
  logic [BUS_WIDTH-1:0] ir;
  logic                 start;
  logic                 imem_ready;
  logic                 dmem_ready;
  logic                 alu_zero;
  logic [REG_SEL_W-1:0] sel_a;
  logic [REG_SEL_W-1:0] sel_b;
  logic [REG_SEL_W-1:0] sel_dest;
  logic                 rd_a_en;
  logic                 rd_b_en;
  logic                 wr_en;
  logic [3:0]           alu_ctrl;
  logic                 imem_read;
  logic                 dmem_read;
  logic                 dmem_write;
  logic                 pc_inc;
  logic                 pc_load;
  logic                 mar_inc;
  logic                 col_inc;
  logic                 row_inc;
  logic                 col_zero;
  logic                 busy;
  logic                 halted;
  logic                 err;
`ifdef CU_PERF_CNT_EN
  logic [CNT_W-1:0]     instr_count;
`endif

  modport master (
    input  ir, start, imem_ready, dmem_ready, alu_zero,
    output sel_a, sel_b, sel_dest, rd_a_en, rd_b_en, wr_en, alu_ctrl,
           imem_read, dmem_read, dmem_write, pc_inc, pc_load,
           mar_inc, col_inc, row_inc, col_zero, busy, halted, err
`ifdef CU_PERF_CNT_EN
    , output instr_count
`endif
  );

  modport slave (
    output ir, start, imem_ready, dmem_ready, alu_zero,
    input  sel_a, sel_b, sel_dest, rd_a_en, rd_b_en, wr_en, alu_ctrl,
           imem_read, dmem_read, dmem_write, pc_inc, pc_load,
           mar_inc, col_inc, row_inc, col_zero, busy, halted, err
`ifdef CU_PERF_CNT_EN
    , input instr_count
`endif
  );
endinterface

// File: rtl/cu_gen2.sv
// cu_gen2: multi-cycle Moore control unit with registered outputs and memory timeouts.
// Define CU_PERF_CNT_EN to add the retired-instruction counter.
module cu_gen2 #(
  parameter int BUS_WIDTH   = 16,
  parameter int OPCODE_LEN  = 4,
  parameter int REG_SEL_W   = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input logic       clk,
  input logic       reset,
  cu_gen2_if.master bus
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_MEM_RD, S_MEM_WR,
    S_JEXEC, S_JEVAL, S_STROBE, S_HALT, S_ERR
  } state_t;

  state_t               r_state, w_next;
  logic [TW-1:0]        r_waitCnt;
  logic [OPCODE_LEN-1:0] w_op;
  logic [3:0]           w_code;
  logic                 w_opStd, w_waiting, w_ready, w_timeout;
  logic [REG_SEL_W-1:0] r_selA, r_selB, r_selD;
  logic                 r_rdA, r_rdB, r_wr, r_imemRd, r_dmemRd, r_dmemWr;
  logic                 r_pcInc, r_pcLoad, r_busy, r_halted, r_err;
  logic [3:0]           r_alu, r_strobe;
  logic                 w_rdA, w_rdB, w_wr, w_imemRd, w_dmemRd, w_dmemWr;
  logic                 w_pcInc, w_pcLoad, w_busy, w_halted, w_err;
  logic [3:0]           w_alu, w_strobe;

  assign w_op   = bus.ir[BUS_WIDTH-1 -: OPCODE_LEN];
  assign w_code = w_op[3:0];

  // Opcodes wider than 4 bits only dispatch when the extra MSBs are zero.
  if (OPCODE_LEN > 4) begin : g_wideOp
    assign w_opStd = ~|w_op[OPCODE_LEN-1:4];
  end else begin : g_narrowOp
    assign w_opStd = 1'b1;
  end

  assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_ready   = (r_state == S_FETCH) ? bus.imem_ready : bus.dmem_ready;
  assign w_timeout = w_waiting && !w_ready && (r_waitCnt == TW'(MEM_TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_waitCnt <= '0;
      r_selA    <= '0;
      r_selB    <= '0;
      r_selD    <= '0;
      r_rdA     <= 1'b0;
      r_rdB     <= 1'b0;
      r_wr      <= 1'b0;
      r_imemRd  <= 1'b0;
      r_dmemRd  <= 1'b0;
      r_dmemWr  <= 1'b0;
      r_pcInc   <= 1'b0;
      r_pcLoad  <= 1'b0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
      r_err     <= 1'b0;
      r_alu     <= 4'b0000;
      r_strobe  <= 4'b0000;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_waitCnt <= '0;
      else if (w_waiting)
        r_waitCnt <= r_waitCnt + 1'b1;
      if (r_state == S_DECODE) begin
        r_selA <= bus.ir[BUS_WIDTH-OPCODE_LEN-1 -: REG_SEL_W];
        r_selB <= bus.ir[BUS_WIDTH-OPCODE_LEN-REG_SEL_W-1 -: REG_SEL_W];
        r_selD <= bus.ir[BUS_WIDTH-OPCODE_LEN-2*REG_SEL_W-1 -: REG_SEL_W];
      end
      r_rdA    <= w_rdA;
      r_rdB    <= w_rdB;
      r_wr     <= w_wr;
      r_imemRd <= w_imemRd;
      r_dmemRd <= w_dmemRd;
      r_dmemWr <= w_dmemWr;
      r_pcInc  <= w_pcInc;
      r_pcLoad <= w_pcLoad;
      r_busy   <= w_busy;
      r_halted <= w_halted;
      r_err    <= w_err;
      r_alu    <= w_alu;
      r_strobe <= w_strobe;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.start) w_next = S_FETCH;
      S_FETCH:  if (bus.imem_ready) w_next = S_DECODE; else if (w_timeout) w_next = S_ERR;
      S_DECODE: begin
        w_next = S_FETCH;
        if (w_opStd) begin
          case (w_code)
            4'h1:                                    w_next = S_MEM_RD;
            4'h2:                                    w_next = S_MEM_WR;
            4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: w_next = S_EXEC;
            4'hA:                                    w_next = S_JEXEC;
            4'hB, 4'hC, 4'hD, 4'hE:                  w_next = S_STROBE;
            4'hF:                                    w_next = S_HALT;
            default:                                 w_next = S_FETCH;
          endcase
        end
      end
      S_EXEC:   w_next = S_WB;
      S_WB:     w_next = S_FETCH;
      S_MEM_RD: if (bus.dmem_ready) w_next = S_WB; else if (w_timeout) w_next = S_ERR;
      S_MEM_WR: if (bus.dmem_ready) w_next = S_FETCH; else if (w_timeout) w_next = S_ERR;
      S_JEXEC:  w_next = S_JEVAL;
      S_JEVAL:  w_next = S_FETCH;
      S_STROBE: w_next = S_FETCH;
      S_HALT:   if (bus.start) w_next = S_FETCH;
      S_ERR:    w_next = S_ERR;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so the registers line up with it;
  // EXEC/JEXEC/STROBE are only entered from DECODE, so the live IR opcode is valid there.
  always_comb begin
    w_imemRd = (w_next == S_FETCH);
    w_dmemRd = (w_next == S_MEM_RD);
    w_dmemWr = (w_next == S_MEM_WR);
    w_rdA    = (w_next == S_EXEC) || (w_next == S_JEXEC) || (w_next == S_MEM_WR);
    w_rdB    = (w_next == S_EXEC) || (w_next == S_JEXEC);
    w_wr     = (w_next == S_WB);
    w_pcInc  = (r_state == S_FETCH) && bus.imem_ready;
    w_pcLoad = (r_state == S_JEVAL) && !bus.alu_zero;
    w_halted = (w_next == S_HALT);
    w_err    = (w_next == S_ERR);
    w_busy   = !((w_next == S_IDLE) || (w_next == S_HALT) || (w_next == S_ERR));
    w_alu    = 4'b0000;
    if (w_next == S_EXEC)       w_alu = w_code - 4'd3;
    else if (w_next == S_WB)    w_alu = r_alu;
    else if (w_next == S_JEXEC) w_alu = 4'b0010;
    w_strobe = 4'b0000;
    if (w_next == S_STROBE) begin
      case (w_code)
        4'hB:    w_strobe = 4'b1000;
        4'hC:    w_strobe = 4'b0100;
        4'hD:    w_strobe = 4'b0010;
        4'hE:    w_strobe = 4'b0001;
        default: w_strobe = 4'b0000;
      endcase
    end
  end

  assign bus.sel_a      = r_selA;
  assign bus.sel_b      = r_selB;
  assign bus.sel_dest   = r_selD;
  assign bus.rd_a_en    = r_rdA;
  assign bus.rd_b_en    = r_rdB;
  assign bus.wr_en      = r_wr;
  assign bus.alu_ctrl   = r_alu;
  assign bus.imem_read  = r_imemRd;
  assign bus.dmem_read  = r_dmemRd;
  assign bus.dmem_write = r_dmemWr;
  assign bus.pc_inc     = r_pcInc;
  assign bus.pc_load    = r_pcLoad;
  assign bus.mar_inc    = r_strobe[3];
  assign bus.col_inc    = r_strobe[2];
  assign bus.row_inc    = r_strobe[1];
  assign bus.col_zero   = r_strobe[0];
  assign bus.busy       = r_busy;
  assign bus.halted     = r_halted;
  assign bus.err        = r_err;

`ifdef CU_PERF_CNT_EN
  logic [CNT_W-1:0] r_instrCount;

  // Counts every DECODE exit, NOP and HALT included; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)
      r_instrCount <= '0;
    else if (r_state == S_DECODE)
      r_instrCount <= r_instrCount + 1'b1;
  end

  assign bus.instr_count = r_instrCount;
`endif
endmodule

// File: tb/tb_cu_gen2.sv
// Testbench for cu_gen2: instruction table with hand-derived summaries, corner
// sequences (timeout, reset mid-access) and random instructions vs a timeline model.
module tb_cu_gen2;
  logic clk = 1'b0;
  logic reset = 1'b1;

  cu_gen2_if #(.BUS_WIDTH(16), .REG_SEL_W(4), .CNT_W(32)) bus ();

  cu_gen2 #(
    .BUS_WIDTH(16), .OPCODE_LEN(4), .REG_SEL_W(4), .MEM_TIMEOUT(15), .CNT_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic imemRd, dmemRd, dmemWr, pcInc, pcLoad, rdA, rdB, wr;
    logic [3:0] alu;
    logic marInc, colInc, rowInc, colZero;
    logic busy, halted, err;
    logic [3:0] selA, selB, selD;
  } outVec_t;

  typedef struct {
    logic [15:0] instr;
    int          fDelay;
    int          mDelay;
    logic        zero;
    int          haltWait;
    int          expCycles;
    int          expWr;
    int          expMem;
    logic [3:0]  expAlu;
    logic [3:0]  expStrobe;
    logic        expPcLoadFirst;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model state: latched register fields, pending jump pulse, retired count.
  logic [3:0]  mSelA = '0, mSelB = '0, mSelD = '0;
  logic        mPendLoad = 1'b0;
  int          mInstr = 0;
  logic [15:0] curIr = '0;

  int         oCycles, oWr, oMem, oSteps;
  logic       oPcLoadFirst;
  logic [3:0] oStrobe, oAlu;

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic outVec_t baseVec();
    outVec_t v;
    v = '0;
    v.selA = mSelA;
    v.selB = mSelB;
    v.selD = mSelD;
    return v;
  endfunction

  function automatic outVec_t readOut();
    outVec_t v;
    v.imemRd = bus.imem_read;  v.dmemRd = bus.dmem_read;  v.dmemWr = bus.dmem_write;
    v.pcInc  = bus.pc_inc;     v.pcLoad = bus.pc_load;    v.rdA = bus.rd_a_en;
    v.rdB    = bus.rd_b_en;    v.wr = bus.wr_en;          v.alu = bus.alu_ctrl;
    v.marInc = bus.mar_inc;    v.colInc = bus.col_inc;    v.rowInc = bus.row_inc;
    v.colZero = bus.col_zero;  v.busy = bus.busy;         v.halted = bus.halted;
    v.err = bus.err;           v.selA = bus.sel_a;        v.selB = bus.sel_b;
    v.selD = bus.sel_dest;
    return v;
  endfunction

  task automatic applyStimulus(input logic st, input logic imr, input logic dmr, input logic z);
    #1;
    bus.ir         = curIr;
    bus.start      = st;
    bus.imem_ready = imr;
    bus.dmem_ready = dmr;
    bus.alu_zero   = z;
  endtask

  task automatic checkOutput(input string name, input outVec_t exp);
    outVec_t act;
    act = readOut();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
`ifdef CU_PERF_CNT_EN
    checks++;
    if (bus.instr_count !== 32'(mInstr)) begin
      errors++;
      $display("[TB] FAIL instr_count @%0t: got %0d, expected %0d", $time, bus.instr_count, mInstr);
    end
`endif
    if (oSteps == 0) oPcLoadFirst = act.pcLoad;
    oSteps++;
    oCycles += int'(act.busy | act.halted);
    oWr     += int'(act.wr);
    oMem    += int'(act.dmemRd | act.dmemWr);
    oStrobe |= {act.marInc, act.colInc, act.rowInc, act.colZero};
    oAlu    |= act.alu;
  endtask

  task automatic stepCycle(input string name, input outVec_t exp, input logic st,
                           input logic imr, input logic dmr, input logic z);
    applyStimulus(st, imr, dmr, z);
    @(negedge clk);
    checkOutput(name, exp);
    @(posedge clk);
  endtask

  task automatic doReset();
    #1 reset = 1'b1;
    @(posedge clk);
    mSelA = '0; mSelB = '0; mSelD = '0;
    mPendLoad = 1'b0;
    mInstr = 0;
    stepCycle("reset", baseVec(), 1'b1, 1'b1, 1'b1, 1'b1);
    #1 reset = 1'b0;
  endtask

  task automatic startFromIdle();
    stepCycle("idle_start", baseVec(), 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Expected per-cycle timeline for one instruction, starting in its first FETCH cycle.
  task automatic runInstr(input logic [15:0] instr, input int fDelay, input int mDelay,
                          input logic zero, input int haltWait);
    outVec_t e;
    int op;
    op = int'(instr[15:12]);
    curIr = instr;
    oCycles = 0; oWr = 0; oMem = 0; oSteps = 0;
    oPcLoadFirst = 1'b0; oStrobe = '0; oAlu = '0;
    for (int k = 0; k <= fDelay; k++) begin
      e = baseVec(); e.busy = 1'b1; e.imemRd = 1'b1;
      e.pcLoad = (k == 0) && mPendLoad;
      stepCycle("fetch", e, rnd(), k == fDelay, rnd(), rnd());
    end
    mPendLoad = 1'b0;
    e = baseVec(); e.busy = 1'b1; e.pcInc = 1'b1;
    stepCycle("decode", e, rnd(), rnd(), rnd(), rnd());
    mSelA = instr[11:8]; mSelB = instr[7:4]; mSelD = instr[3:0];
    mInstr++;
    case (op)
      1: begin
        for (int k = 0; k <= mDelay; k++) begin
          e = baseVec(); e.busy = 1'b1; e.dmemRd = 1'b1;
          stepCycle("mem_rd", e, rnd(), rnd(), k == mDelay, rnd());
        end
        e = baseVec(); e.busy = 1'b1; e.wr = 1'b1;
        stepCycle("load_wb", e, rnd(), rnd(), rnd(), rnd());
      end
      2: begin
        for (int k = 0; k <= mDelay; k++) begin
          e = baseVec(); e.busy = 1'b1; e.rdA = 1'b1; e.dmemWr = 1'b1;
          stepCycle("mem_wr", e, rnd(), rnd(), k == mDelay, rnd());
        end
      end
      3, 4, 5, 6, 7, 8, 9: begin
        e = baseVec(); e.busy = 1'b1; e.rdA = 1'b1; e.rdB = 1'b1; e.alu = 4'(op - 3);
        stepCycle("exec", e, rnd(), rnd(), rnd(), rnd());
        e = baseVec(); e.busy = 1'b1; e.wr = 1'b1; e.alu = 4'(op - 3);
        stepCycle("alu_wb", e, rnd(), rnd(), rnd(), rnd());
      end
      10: begin
        e = baseVec(); e.busy = 1'b1; e.rdA = 1'b1; e.rdB = 1'b1; e.alu = 4'b0010;
        stepCycle("jexec", e, rnd(), rnd(), rnd(), rnd());
        e = baseVec(); e.busy = 1'b1;
        stepCycle("jeval", e, rnd(), rnd(), rnd(), zero);
        mPendLoad = !zero;
      end
      11, 12, 13, 14: begin
        e = baseVec(); e.busy = 1'b1;
        e.marInc = (op == 11); e.colInc = (op == 12); e.rowInc = (op == 13); e.colZero = (op == 14);
        stepCycle("strobe", e, rnd(), rnd(), rnd(), rnd());
      end
      15: begin
        for (int k = 0; k <= haltWait; k++) begin
          e = baseVec(); e.halted = 1'b1;
          stepCycle("halt", e, k == haltWait, rnd(), rnd(), rnd());
        end
      end
      default: ;
    endcase
  endtask

  vec_t tbl[18];

  initial begin
    outVec_t e;
    logic [15:0] ri;
    int fd, md;

    tbl[0]  = '{16'h4123,  0, 0, 1'b0, 0,  4, 1, 0, 4'h1, 4'h0, 1'b0};
    tbl[1]  = '{16'h1005,  0, 3, 1'b0, 0,  7, 1, 4, 4'h0, 4'h0, 1'b0};
    tbl[2]  = '{16'hA120,  0, 0, 1'b0, 0,  4, 0, 0, 4'h2, 4'h0, 1'b0};
    tbl[3]  = '{16'h0000,  0, 0, 1'b0, 0,  2, 0, 0, 4'h0, 4'h0, 1'b1};
    tbl[4]  = '{16'hA120,  0, 0, 1'b1, 0,  4, 0, 0, 4'h2, 4'h0, 1'b0};
    tbl[5]  = '{16'h0000,  0, 0, 1'b0, 0,  2, 0, 0, 4'h0, 4'h0, 1'b0};
    tbl[6]  = '{16'hB000,  0, 0, 1'b0, 0,  3, 0, 0, 4'h0, 4'h8, 1'b0};
    tbl[7]  = '{16'hC000,  0, 0, 1'b0, 0,  3, 0, 0, 4'h0, 4'h4, 1'b0};
    tbl[8]  = '{16'hD000,  0, 0, 1'b0, 0,  3, 0, 0, 4'h0, 4'h2, 1'b0};
    tbl[9]  = '{16'hE000,  0, 0, 1'b0, 0,  3, 0, 0, 4'h0, 4'h1, 1'b0};
    tbl[10] = '{16'h2345,  2, 1, 1'b0, 0,  6, 0, 2, 4'h0, 4'h0, 1'b0};
    tbl[11] = '{16'h8ABC, 15, 0, 1'b0, 0, 19, 1, 0, 4'h5, 4'h0, 1'b0};
    tbl[12] = '{16'h9DEF,  1, 0, 1'b0, 0,  5, 1, 0, 4'h6, 4'h0, 1'b0};
    tbl[13] = '{16'hF000,  0, 0, 1'b0, 3,  6, 0, 0, 4'h0, 4'h0, 1'b0};
    tbl[14] = '{16'h3456,  0, 0, 1'b0, 0,  4, 1, 0, 4'h0, 4'h0, 1'b0};
    tbl[15] = '{16'h5111,  0, 0, 1'b0, 0,  4, 1, 0, 4'h2, 4'h0, 1'b0};
    tbl[16] = '{16'h6222,  0, 0, 1'b0, 0,  4, 1, 0, 4'h3, 4'h0, 1'b0};
    tbl[17] = '{16'h7333,  0, 0, 1'b0, 0,  4, 1, 0, 4'h4, 4'h0, 1'b0};

    bus.ir = '0; bus.start = 1'b0; bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0; bus.alu_zero = 1'b0;

    doReset();
    stepCycle("idle_hold", baseVec(), 1'b0, 1'b1, 1'b1, 1'b0);
    startFromIdle();

    for (int i = 0; i < 18; i++) begin
      runInstr(tbl[i].instr, tbl[i].fDelay, tbl[i].mDelay, tbl[i].zero, tbl[i].haltWait);
      checks++;
      if (oCycles != tbl[i].expCycles || oWr != tbl[i].expWr || oMem != tbl[i].expMem ||
          oAlu !== tbl[i].expAlu || oStrobe !== tbl[i].expStrobe ||
          oPcLoadFirst !== tbl[i].expPcLoadFirst) begin
        errors++;
        $display("[TB] FAIL table[%0d] %h: got cyc=%0d wr=%0d mem=%0d alu=%h strb=%h pl=%b, expected cyc=%0d wr=%0d mem=%0d alu=%h strb=%h pl=%b",
                 i, tbl[i].instr, oCycles, oWr, oMem, oAlu, oStrobe, oPcLoadFirst,
                 tbl[i].expCycles, tbl[i].expWr, tbl[i].expMem, tbl[i].expAlu,
                 tbl[i].expStrobe, tbl[i].expPcLoadFirst);
      end
    end

    // Instruction fetch that never completes: 16 waiting cycles, then sticky error.
    doReset();
    startFromIdle();
    curIr = 16'h4123;
    for (int k = 0; k < 16; k++) begin
      e = baseVec(); e.busy = 1'b1; e.imemRd = 1'b1;
      stepCycle("timeout_wait", e, rnd(), 1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      e = baseVec(); e.err = 1'b1;
      stepCycle("err_sticky", e, 1'b1, 1'b1, 1'b1, 1'b0);
    end
    doReset();
    stepCycle("after_err_idle", baseVec(), 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a pending data read aborts it on the same edge.
    startFromIdle();
    curIr = 16'h1005;
    e = baseVec(); e.busy = 1'b1; e.imemRd = 1'b1;
    stepCycle("abort_fetch", e, 1'b0, 1'b1, 1'b0, 1'b0);
    e = baseVec(); e.busy = 1'b1; e.pcInc = 1'b1;
    stepCycle("abort_decode", e, 1'b0, 1'b0, 1'b0, 1'b0);
    mSelA = 4'h0; mSelB = 4'h0; mSelD = 4'h5; mInstr++;
    for (int k = 0; k < 2; k++) begin
      e = baseVec(); e.busy = 1'b1; e.dmemRd = 1'b1;
      stepCycle("abort_memrd", e, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    doReset();
    stepCycle("abort_idle0", baseVec(), 1'b0, 1'b0, 1'b1, 1'b0);
    stepCycle("abort_idle1", baseVec(), 1'b0, 1'b0, 1'b1, 1'b0);

    // Random instruction stream; occasional worst-case waits right at the timeout limit.
    startFromIdle();
    for (int i = 0; i < 150; i++) begin
      ri = 16'($urandom);
      fd = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
      md = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
      runInstr(ri, fd, md, rnd(), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
